// File: rtl/wb_pkg.sv
// Shared types and load funct3 encodings for the write-back controller.
package wb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_MEM
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_ctrl_load_align.sv
// Combinational load alignment: selects byte/half/word by offset, extends per funct3,
// and flags illegal funct3 or misaligned accesses.
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[{offset, 3'b000} +: 8];
        half_sel = raw[{offset[1], 4'b0000} +: 16];
        data     = '0;
        err      = 1'b0;
        case (funct3)
            F3_LB:  data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
            F3_LH: begin
                data = {{(DATA_W-16){half_sel[15]}}, half_sel};
                err  = offset[0];
            end
            F3_LHU: begin
                data = {{(DATA_W-16){1'b0}}, half_sel};
                err  = offset[0];
            end
            F3_LW: begin
                data = raw;
                err  = (offset != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_ctrl.sv
// Register-file write-back controller: ALU results and aligned load data, x0 masking, load stall.
// Optional response watchdog enabled by defining WB_TIMEOUT_EN.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_offset,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              write_back_en,
    output logic              stall,
    output logic              ld_err
`ifdef WB_TIMEOUT_EN
    ,
    output logic              ld_timeout
`endif
);

    wb_state_t         state, next_state;
    logic [ADDR_W-1:0] pend_rd;
    logic [2:0]        pend_f3;
    logic [1:0]        pend_off;

    logic              alu_fire, ld_fire, rsp_fire, tmo_hit;
    logic [2:0]        align_f3;
    logic [1:0]        align_off;
    logic [DATA_W-1:0] align_data;
    logic              align_err;

    // One aligner serves both phases: in IDLE it vets the incoming load,
    // in WAIT_MEM it formats the response using the latched load fields.
    load_align #(.DATA_W(DATA_W)) u_align (
        .raw    (mem_rsp_data),
        .funct3 (align_f3),
        .offset (align_off),
        .data   (align_data),
        .err    (align_err)
    );

`ifdef WB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit = (state == WAIT_MEM) && !mem_rsp_valid
                     && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt    <= '0;
            ld_timeout <= 1'b0;
        end else begin
            ld_timeout <= tmo_hit;
            if (state != WAIT_MEM || tmo_hit)
                tmo_cnt <= '0;
            else if (!mem_rsp_valid)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        next_state = state;
        alu_ready  = 1'b0;
        ld_ready   = 1'b0;
        stall      = 1'b0;
        align_f3   = ld_funct3;
        align_off  = ld_offset;
        case (state)
            IDLE: begin
                alu_ready = 1'b1;
                ld_ready  = !alu_valid;
                if (ld_valid && !alu_valid && !align_err)
                    next_state = WAIT_MEM;
            end
            WAIT_MEM: begin
                stall     = 1'b1;
                align_f3  = pend_f3;
                align_off = pend_off;
                if (mem_rsp_valid || tmo_hit)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign alu_fire = alu_valid && alu_ready;
    assign ld_fire  = ld_valid && ld_ready;
    assign rsp_fire = (state == WAIT_MEM) && mem_rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pend_rd       <= '0;
            pend_f3       <= '0;
            pend_off      <= '0;
            wr_addr       <= '0;
            wr_data       <= '0;
            write_back_en <= 1'b0;
            ld_err        <= 1'b0;
        end else begin
            state         <= next_state;
            write_back_en <= 1'b0;
            ld_err        <= ld_fire && align_err;
            if (ld_fire && !align_err) begin
                pend_rd  <= ld_rd;
                pend_f3  <= ld_funct3;
                pend_off <= ld_offset;
            end
            if (alu_fire && alu_rd != '0) begin
                write_back_en <= 1'b1;
                wr_addr       <= alu_rd;
                wr_data       <= alu_result;
            end else if (rsp_fire && pend_rd != '0) begin
                write_back_en <= 1'b1;
                wr_addr       <= pend_rd;
                wr_data       <= align_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl with a write scoreboard checked every cycle.
module tb_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        write_back_en, stall, ld_err;
`ifdef WB_TIMEOUT_EN
    logic        ld_timeout;
`endif

    wb_ctrl #(.DATA_W(32), .ADDR_W(5), .TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_result    (alu_result),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd         (ld_rd),
        .ld_funct3     (ld_funct3),
        .ld_offset     (ld_offset),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .write_back_en (write_back_en),
        .stall         (stall),
        .ld_err        (ld_err)
`ifdef WB_TIMEOUT_EN
        ,
        .ld_timeout    (ld_timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_mism = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load formatting, written from the ISA definition.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (int'(off) * 8);
        case (f3)
            3'b000: ref_load = {{24{sh[7]}}, sh[7:0]};
            3'b100: ref_load = {24'h0, sh[7:0]};
            3'b001: ref_load = {{16{sh[15]}}, sh[15:0]};
            3'b101: ref_load = {16'h0, sh[15:0]};
            default: ref_load = w;
        endcase
    endfunction

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        sb.push_back('{cyc + 1, a, d});
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("wb_en", {31'b0, write_back_en}, 32'd1);
            chk("wr_addr", {27'b0, wr_addr}, {27'b0, e.addr});
            chk("wr_data", wr_data, e.data);
        end else begin
            chk("wb_quiet", {31'b0, write_back_en}, 32'd0);
        end
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] word, input int gap, input logic [31:0] exp_d);
        ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_offset = off;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            chk("stall_wait", {31'b0, stall}, 32'd1);
            tick();
        end
        chk("stall_rsp", {31'b0, stall}, 32'd1);
        mem_rsp_valid = 1'b1; mem_rsp_data = word;
        if (rd != 5'd0) expect_wr(rd, exp_d);
        tick();
        mem_rsp_valid = 1'b0;
        chk("stall_done", {31'b0, stall}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_offset = '0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        tick(); tick();
        chk("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_ld_err", {31'b0, ld_err}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_alu_ready", {31'b0, alu_ready}, 32'd1);
        chk("idle_ld_ready", {31'b0, ld_ready}, 32'd1);

        // ALU write, strobe low afterwards with held values
        alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        alu_valid = 1'b0;
        tick();
        chk("hold_addr", {27'b0, wr_addr}, 32'd5);
        chk("hold_data", wr_data, 32'hDEADBEEF);

        // LB sign extend, response on the third stalled cycle
        do_load(5'd3, 3'b000, 2'd2, 32'h0080_1234, 2, 32'hFFFF_FF80);
        // LHU upper half and x0 masking
        do_load(5'd7, 3'b101, 2'd2, 32'h8001_0000, 0, 32'h0000_8001);
        do_load(5'd0, 3'b101, 2'd2, 32'h8001_0000, 1, 32'h0);
        chk("x0_hold_addr", {27'b0, wr_addr}, 32'd7);
        // Further alignment patterns checked against the reference model
        do_load(5'd9, 3'b001, 2'd2, 32'h8765_4321, 0, ref_load(3'b001, 2'd2, 32'h8765_4321));
        do_load(5'd10, 3'b100, 2'd3, 32'hF00D_CAFE, 1, ref_load(3'b100, 2'd3, 32'hF00D_CAFE));
        do_load(5'd11, 3'b010, 2'd0, 32'h1357_9BDF, 0, ref_load(3'b010, 2'd0, 32'h1357_9BDF));
        do_load(5'd12, 3'b000, 2'd1, 32'h0000_7F00, 0, 32'h0000_007F);

        // Misaligned LW and illegal funct3: error pulse, no write, stays idle
        ld_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'b010; ld_offset = 2'd1;
        tick();
        ld_valid = 1'b0;
        chk("mis_ld_err", {31'b0, ld_err}, 32'd1);
        chk("mis_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("mis_err_clear", {31'b0, ld_err}, 32'd0);
        ld_valid = 1'b1; ld_funct3 = 3'b110; ld_offset = 2'd0;
        tick();
        ld_valid = 1'b0;
        chk("ill_ld_err", {31'b0, ld_err}, 32'd1);
        chk("ill_stall", {31'b0, stall}, 32'd0);
        ld_valid = 1'b1; ld_funct3 = 3'b001; ld_offset = 2'd3;
        tick();
        ld_valid = 1'b0;
        chk("mis_lh_err", {31'b0, ld_err}, 32'd1);

        // Contention: ALU wins, load accepted next cycle
        alu_valid = 1'b1; alu_rd = 5'd8; alu_result = 32'h0000_00A5;
        ld_valid = 1'b1; ld_rd = 5'd6; ld_funct3 = 3'b010; ld_offset = 2'd0;
        #1;
        chk("cont_ld_ready", {31'b0, ld_ready}, 32'd0);
        chk("cont_alu_ready", {31'b0, alu_ready}, 32'd1);
        expect_wr(5'd8, 32'h0000_00A5);
        tick();
        alu_valid = 1'b0;
        #1;
        chk("cont_ld_ready2", {31'b0, ld_ready}, 32'd1);
        tick();
        ld_valid = 1'b0;
        chk("cont_stall", {31'b0, stall}, 32'd1);
        chk("wait_alu_ready", {31'b0, alu_ready}, 32'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h600D_F00D;
        expect_wr(5'd6, 32'h600D_F00D);
        // Back-to-back ALU offered during the response cycle is held off until idle
        alu_valid = 1'b1; alu_rd = 5'd2; alu_result = 32'h1111_2222;
        tick();
        mem_rsp_valid = 1'b0;
        expect_wr(5'd2, 32'h1111_2222);
        tick();
        alu_valid = 1'b0;

        // Response in IDLE, and in the accept cycle, is ignored
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
        tick();
        ld_valid = 1'b1; ld_rd = 5'd13; ld_funct3 = 3'b010; ld_offset = 2'd0;
        tick();
        ld_valid = 1'b0;
        chk("acc_rsp_stall", {31'b0, stall}, 32'd1);
        mem_rsp_data = 32'h2468_ACE0;
        expect_wr(5'd13, 32'h2468_ACE0);
        tick();
        mem_rsp_valid = 1'b0;

        // Reset mid-load drops the pending write
        ld_valid = 1'b1; ld_rd = 5'd14; ld_funct3 = 3'b010; ld_offset = 2'd0;
        tick();
        ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777_7777;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rstmid_stall", {31'b0, stall}, 32'd0);
        chk("rstmid_addr", {27'b0, wr_addr}, 32'd0);
        chk("rstmid_alu_ready", {31'b0, alu_ready}, 32'd1);
        tick();

`ifdef WB_TIMEOUT_EN
        // No response: four stalled cycles then timeout pulse
        ld_valid = 1'b1; ld_rd = 5'd15; ld_funct3 = 3'b010; ld_offset = 2'd0;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo_stall", {31'b0, stall}, 32'd1);
            tick();
        end
        chk("tmo_pulse", {31'b0, ld_timeout}, 32'd1);
        chk("tmo_idle", {31'b0, stall}, 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd16; alu_result = 32'hABCD_0123;
        expect_wr(5'd16, 32'hABCD_0123);
        tick();
        alu_valid = 1'b0;
        chk("tmo_pulse_end", {31'b0, ld_timeout}, 32'd0);
        // Response on the limit cycle wins
        ld_valid = 1'b1; ld_rd = 5'd17; ld_funct3 = 3'b010; ld_offset = 2'd0;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("lim_stall", {31'b0, stall}, 32'd1);
            if (i == 3) begin
                mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0F0F_F0F0;
                expect_wr(5'd17, 32'h0F0F_F0F0);
            end
            tick();
        end
        mem_rsp_valid = 1'b0;
        chk("lim_no_tmo", {31'b0, ld_timeout}, 32'd0);
        chk("lim_idle", {31'b0, stall}, 32'd0);
`endif

        tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
Write-back controller driving the register file write port (wr_addr, wr_data, write_back_en) of the single-cycle/multi-cycle RISC-V core.
Accepts ALU results and load requests, waits for the data-memory response, aligns and extends load data by funct3/offset, and masks x0.
Stalls the core while a load is outstanding.

Parameters:
DATA_W, 32, register/data width
ADDR_W, 5, register address width
TIMEOUT_CYCLES, 16, memory-response watchdog limit (used only with WB_TIMEOUT_EN)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous, active-high reset
alu_valid  in  1  ALU result offered this cycle
alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
alu_rd  in  ADDR_W  destination register
alu_result  in  DATA_W  ALU result
ld_valid  in  1  load issued
ld_ready  out  1  load accepted when ld_valid && ld_ready
ld_rd  in  ADDR_W  load destination
ld_funct3  in  3  load type
ld_offset  in  2  byte address bits [1:0]
mem_rsp_valid  in  1  memory read data valid
mem_rsp_data  in  DATA_W  raw 32-bit aligned word
wr_addr  out  ADDR_W  register file write address
wr_data  out  DATA_W  register file write data
write_back_en  out  1  register file write strobe
stall  out  1  load outstanding
ld_err  out  1  one-cycle pulse: illegal funct3 or misaligned load
(with WB_TIMEOUT_EN) ld_timeout  out  1  one-cycle pulse: response timeout

Behaviour:
- Reset values: wr_addr=0, wr_data=0, write_back_en=0, ld_err=0, ld_timeout=0; state=IDLE; pending rd/funct3/offset cleared.
- States: IDLE, WAIT_MEM.
- IDLE: alu_ready=1; ld_ready=~alu_valid, so ALU wins when both are valid.
- ALU accept: next cycle write_back_en=1, wr_addr=alu_rd, wr_data=alu_result. Latency is 1 cycle.
- Load accept: latch rd/funct3/offset and go to WAIT_MEM.
  - Illegal funct3 (011, 110, 111): stay IDLE, pulse ld_err next cycle, no write.
  - Misaligned (LH/LHU with offset 1 or 3, LW with offset != 0): stay IDLE, pulse ld_err next cycle, no write.
- WAIT_MEM: alu_ready=0, ld_ready=0, stall=1 (stall is combinational from state).
  - On mem_rsp_valid: next cycle write_back_en=1, wr_addr=pending rd, wr_data=aligned data; return to IDLE.
  - The cycle after return, new accepts are allowed. A back-to-back ALU result writes the cycle after the load write.
- Alignment:
  - LB (000) / LBU (100): byte = data[8*offset +: 8], sign- or zero-extended.
  - LH (001) / LHU (101): half = data[16*offset[1] +: 16], sign- or zero-extended.
  - LW (010): full word.
- x0: rd==0 never asserts write_back_en. Processing, state transitions and errors still occur.
- write_back_en is a single-cycle pulse per accepted op. wr_addr/wr_data hold their last value while the strobe is low.
- mem_rsp_valid in IDLE is ignored, including a response in the same cycle a load is accepted.
- Reset mid-WAIT_MEM: return to IDLE, drop the pending load, no write. A late response is ignored.

Optional Feature:
WB_TIMEOUT_EN:
- Defined: counter starts at 0 on WAIT_MEM entry and increments each cycle without mem_rsp_valid. When the count reaches TIMEOUT_CYCLES: return to IDLE, pulse ld_timeout, no write. A response in the same cycle as the limit wins.
- Undefined: no counter and no ld_timeout port; WAIT_MEM waits indefinitely.

Decomposition:
- Package wb_pkg:
  - wb_state_t enum {IDLE, WAIT_MEM}
  - funct3 localparams F3_LB=3'b000, F3_LH=3'b001, F3_LW=3'b010, F3_LBU=3'b100, F3_LHU=3'b101
- Sub-module load_align: combinational; inputs raw word, funct3, offset; outputs aligned data and err flag.

Test Plan:
- ALU write: alu_valid, rd=5, result=32'hDEADBEEF -> next cycle write_back_en=1, wr_addr=5, wr_data=32'hDEADBEEF; strobe low the cycle after.
- LB sign-extend: ld rd=3, funct3=000, offset=2; response 32'h0080_1234 after 3 cycles -> stall=1 for 3 cycles, then wr_data=32'hFFFF_FF80, wr_addr=3.
- LHU/x0 and misalign:
  - LHU offset=2, data 32'h8001_0000 -> wr_data=32'h0000_8001.
  - Same load with rd=0 -> no write_back_en.
  - LW offset=1 -> ld_err pulse, no write, stays IDLE.
- Contention: alu_valid and ld_valid in the same IDLE cycle -> ALU written; ld_ready=0; load accepted the following cycle.
- Reset mid-load: rst during WAIT_MEM, then mem_rsp_valid -> no write_back_en, stall=0, state IDLE.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=4: no response -> ld_timeout pulse, no write, ALU accepted afterward. Response arriving on the 4th cycle -> normal write, no timeout.
